// File: rtl/seq_detect_ctrl_if.sv
// Producer/config/result bundle between a word-oriented master and seq_detect_ctrl.
interface seq_detect_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 3,
  parameter int CNT_W  = 8
);
  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              cfg_overlap;
  logic [CNT_W-1:0]  cfg_thresh;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              clr_cnt;
  logic              match;
  logic [CNT_W-1:0]  match_cnt;
  logic              irq;
  logic              busy;

  modport master (
    output cfg_we, cfg_pattern, cfg_overlap, cfg_thresh, in_valid, in_data, clr_cnt,
    input  in_ready, match, match_cnt, irq, busy
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_overlap, cfg_thresh, in_valid, in_data, clr_cnt,
    output in_ready, match, match_cnt, irq, busy
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Serializes accepted words MSB-first into a programmable pattern detector,
// with overlap control, a saturating match counter and a sticky threshold irq.
module seq_detect_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 3,
  parameter int CNT_W  = 8
) (
  input logic             clk,
  input logic             rst,
  seq_detect_ctrl_if.slave bus
);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [PAT_W-1:0] PAT_RST = PAT_W'((1 << (PAT_W - 1)) | 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic [PAT_W-1:0]  pattern_q, hist_q, hist_d;
  logic              overlap_q;
  logic [CNT_W-1:0]  thresh_q, cnt_q, cnt_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, irq_q, irq_d;
  logic              hit, accept, cfg_load;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W-1:0] v);
    return (v == FILL_W'(PAT_W)) ? v : v + FILL_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    accept       = 1'b0;
    cfg_load     = 1'b0;
    hist_d       = hist_q;
    fill_d       = fill_q;
    hit          = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        cfg_load     = bus.cfg_we;
        accept       = bus.in_valid;
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        bus.busy = 1'b1;
        hist_d   = PAT_W'({hist_q, word_q[idx_q]});
        fill_d   = sat_fill(fill_q);
        hit      = (fill_d == FILL_W'(PAT_W)) && (hist_d == pattern_q);
        // Non-overlapping mode: bits that formed a match may not start the next one.
        if (hit && !overlap_q) fill_d = '0;
        if (idx_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter clear takes priority over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    irq_d = irq_q;
    if (bus.clr_cnt) begin
      cnt_d = '0;
      irq_d = 1'b0;
    end else begin
      if (hit) cnt_d = sat_inc(cnt_q);
      if ((thresh_q != '0) && (cnt_d >= thresh_q)) irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q     <= '0;
      pattern_q <= PAT_RST;
      overlap_q <= 1'b0;
      thresh_q  <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (accept)                idx_q <= IDX_W'(DATA_W - 1);
      else if (state_q == SHIFT) idx_q <= idx_q - IDX_W'(1);
      if (cfg_load) begin
        pattern_q <= bus.cfg_pattern;
        overlap_q <= bus.cfg_overlap;
        thresh_q  <= bus.cfg_thresh;
        hist_q    <= '0;
        fill_q    <= '0;
      end else begin
        hist_q <= hist_d;
        fill_q <= fill_d;
      end
      match_q <= hit;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) word_q <= bus.in_data;
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.irq       = irq_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Randomized bench for seq_detect_ctrl with a bit-stream reference model and scoreboard.
module tb_seq_detect_ctrl;
  localparam int DATA_W  = 8;
  localparam int PAT_W   = 3;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic             m;
    logic [CNT_W-1:0] c;
    logic             i;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();
  seq_detect_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  exp_t sb[$];

  // reference model state: every bit seen since last config/reset
  bit               bits[$];
  int               ustart;
  logic [PAT_W-1:0] mpat;
  bit               mov;
  int               mthr, mcnt;
  bit               mirq;
  logic [PAT_W-1:0] cp;
  bit               cov;
  logic [CNT_W-1:0] cthr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete(); ustart = 0; mpat = 3'b101; mov = 0; mthr = 0; mcnt = 0; mirq = 0;
  endtask

  task automatic model_cfg(input logic [PAT_W-1:0] p, input bit ov, input int thr);
    mpat = p; mov = ov; mthr = thr; bits.delete(); ustart = 0;
  endtask

  task automatic model_bit(input bit b, input bit clr);
    exp_t e;
    bit hit;
    int n;
    bits.push_back(b);
    n = bits.size();
    hit = 0;
    if (n - ustart >= PAT_W) begin
      hit = 1;
      for (int k = 0; k < PAT_W; k++)
        if (bits[n-1-k] != mpat[k]) hit = 0;
    end
    if (hit && !mov) ustart = n;
    if (clr) begin
      mcnt = 0; mirq = 0;
    end else begin
      if (hit && mcnt < CNT_MAX) mcnt++;
      if (mthr != 0 && mcnt >= mthr) mirq = 1;
    end
    e.m = hit; e.c = CNT_W'(mcnt); e.i = mirq;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_cfg(input logic [PAT_W-1:0] p, input bit ov, input logic [CNT_W-1:0] thr);
    bus.cfg_we = 1; bus.cfg_pattern = p; bus.cfg_overlap = ov; bus.cfg_thresh = thr;
    @(posedge clk); #1;
    bus.cfg_we = 0;
    model_cfg(p, ov, int'(thr));
  endtask

  task automatic do_clr();
    bus.clr_cnt = 1;
    @(posedge clk); #1;
    bus.clr_cnt = 0;
    mcnt = 0; mirq = 0;
  endtask

  // clr_bit/junk_bit/rst_bit select the bit cycle (0..7) for a side event, -1 for none
  task automatic send_word(input logic [DATA_W-1:0] w, input int clr_bit, input bit cfg_now,
                           input int junk_bit, input int rst_bit);
    int t;
    if (cfg_now) begin
      bus.cfg_we = 1; bus.cfg_pattern = cp; bus.cfg_overlap = cov; bus.cfg_thresh = cthr;
      model_cfg(cp, cov, int'(cthr));
    end
    for (int j = 0; j < DATA_W; j++) model_bit(w[DATA_W-1-j], j == clr_bit);
    bus.in_valid = 1; bus.in_data = w;
    t = 0;
    while (!bus.in_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) chk("ready_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    bus.in_valid = 0; bus.cfg_we = 0; bus.in_data = DATA_W'($urandom);
    for (int j = 0; j < DATA_W; j++) begin
      if (j == rst_bit) begin
        rst = 0; #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_match", 32'(bus.match), 32'(0));
        chk("rst_cnt", 32'(bus.match_cnt), 32'(0));
        chk("rst_irq", 32'(bus.irq), 32'(0));
        sb.delete();
        model_reset();
        @(posedge clk); #1;
        rst = 1;
        return;
      end
      chk("in_ready_low", 32'(bus.in_ready), 32'(0));
      if (j == clr_bit) bus.clr_cnt = 1;
      if (j == junk_bit) begin
        bus.cfg_we = 1; bus.cfg_pattern = 3'b111; bus.cfg_overlap = 1; bus.cfg_thresh = 1;
      end
      @(posedge clk); #1;
      bus.clr_cnt = 0; bus.cfg_we = 0;
    end
    chk("in_ready_high", 32'(bus.in_ready), 32'(1));
  endtask

  // scoreboard monitor: the cycle after each serialized bit shows its match/count/irq
  bit prev_busy = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) prev_busy = 0;
    else begin
      if (bus.match === 1'b1) pulses++;
      if (prev_busy) begin
        if (sb.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
        else begin
          e = sb.pop_front();
          chk("match", 32'(bus.match), 32'(e.m));
          chk("match_cnt", 32'(bus.match_cnt), 32'(e.c));
          chk("irq", 32'(bus.irq), 32'(e.i));
        end
      end
      prev_busy = bus.busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_overlap = 0; bus.cfg_thresh = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.clr_cnt = 0;
    model_reset();
    #3 rst = 0;
    idle(3);
    chk("reset_in_ready", 32'(bus.in_ready), 32'(1));
    chk("reset_busy", 32'(bus.busy), 32'(0));
    chk("reset_match", 32'(bus.match), 32'(0));
    chk("reset_cnt", 32'(bus.match_cnt), 32'(0));
    chk("reset_irq", 32'(bus.irq), 32'(0));
    rst = 1;
    idle(2);

    // defaults: pattern 101, non-overlapping
    base = pulses;
    send_word(8'hAA, -1, 0, -1, -1); idle(1);
    chk("aa_nonovl_cnt", 32'(bus.match_cnt), 32'(2));
    chk("aa_nonovl_pulses", 32'(pulses - base), 32'(2));

    do_cfg(3'b101, 1, 0); do_clr();
    base = pulses;
    send_word(8'hAA, -1, 0, -1, -1); idle(1);
    chk("aa_ovl_cnt", 32'(bus.match_cnt), 32'(3));
    chk("aa_ovl_pulses", 32'(pulses - base), 32'(3));

    do_cfg(3'b101, 0, 0); do_clr();
    base = pulses;
    send_word(8'h02, -1, 0, -1, -1);
    send_word(8'h80, -1, 0, -1, -1); idle(1);
    chk("span_cnt", 32'(bus.match_cnt), 32'(1));
    chk("span_pulses", 32'(pulses - base), 32'(1));

    // config with the same-cycle handshake applies to that word
    do_clr();
    cp = 3'b101; cov = 1; cthr = 3;
    send_word(8'hAA, -1, 1, -1, -1); idle(1);
    chk("thr_irq", 32'(bus.irq), 32'(1));
    chk("thr_cnt", 32'(bus.match_cnt), 32'(3));
    idle(2);
    chk("irq_sticky", 32'(bus.irq), 32'(1));
    do_clr();
    chk("clr_cnt", 32'(bus.match_cnt), 32'(0));
    chk("clr_irq", 32'(bus.irq), 32'(0));
    send_word(8'hAA, 2, 0, -1, -1); idle(1);
    chk("clr_vs_hit_cnt", 32'(bus.match_cnt), 32'(2));
    chk("clr_vs_hit_irq", 32'(bus.irq), 32'(0));

    do_cfg(3'b101, 0, 0); do_clr();
    send_word(8'hAA, -1, 0, 1, -1); idle(1);
    chk("cfg_in_shift_cnt", 32'(bus.match_cnt), 32'(2));
    chk("cfg_in_shift_irq", 32'(bus.irq), 32'(0));

    send_word(8'hAA, -1, 0, -1, 4);
    chk("post_rst_ready", 32'(bus.in_ready), 32'(1));
    send_word(8'hAA, -1, 0, -1, -1); idle(1);
    chk("post_rst_default_cnt", 32'(bus.match_cnt), 32'(2));

    do_cfg(3'b000, 1, 0); do_clr();
    for (int k = 0; k < 40; k++) send_word(8'h00, -1, 0, -1, -1);
    idle(1);
    chk("saturate_cnt", 32'(bus.match_cnt), 32'(CNT_MAX));

    for (int r = 0; r < 60; r++) begin
      if (r % 8 == 0) do_cfg(PAT_W'($urandom), 1'($urandom), CNT_W'($urandom_range(0, 12)));
      if ($urandom_range(0, 9) == 0) do_clr();
      cp = PAT_W'($urandom); cov = 1'($urandom); cthr = CNT_W'($urandom_range(0, 12));
      send_word(DATA_W'($urandom),
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DATA_W - 1)) : -1,
                (r % 8 == 4), -1, -1);
      idle($urandom_range(0, 2));
    end

    idle(4);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
